gen_pattern_seq: RTL and testbench
==================================

// Module: gen_pattern_seq
// PURPOSE
//  Synthesizable periodic-waveform sequencer: replays a programmable table of
//  (level, length) segments on wave_out, looping continuously. Generates
//  the stimulus patterns (clocks, duty-cycle waves, irregular repeating
//  patterns) that the bench-level signal generators produce, so the patterns
//  can also run on silicon. Sits between a config master and the consumer.
// PARAMETERS
//  SEG_NUM  4  number of table entries (>=2)
//  SEG_AW   2  table index width, clog2(SEG_NUM)
//  CNT_W    8  segment length width in clk cycles
//  LOOP_W   8  loop-count width (used only with GEN_LOOP_CNT_EN)
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  cfg_wr     in   1       table write strobe
//  cfg_addr   in   SEG_AW  table entry to write
//  cfg_level  in   1       output level for the entry
//  cfg_len    in   CNT_W   entry duration in cycles (0 treated as 1)
//  seg_last   in   SEG_AW  index of last active entry, sampled on start
//  loop_num   in   LOOP_W  loops to run, 0=infinite, sampled on start
//  start      in   1       1-cycle start request
//  stop       in   1       1-cycle abort request
//  busy       out  1       1 while sequencing
//  wave_out   out  1       generated waveform
//  seg_idx    out  SEG_AW  index of entry currently driven
//  wrap       out  1       1-cycle pulse in last cycle of entry seg_last
//  cfg_err    out  1       1-cycle pulse: write dropped because busy
//  done       out  1       1-cycle pulse: loop_num loops completed
// BEHAVIOUR
//  - Reset: busy=0, wave_out=0, seg_idx=0, wrap=0, cfg_err=0, done=0;
//    table cleared to level=0, len=1; state=IDLE; seg_last latch=0.
//  - FSM: IDLE -> RUN on start (stop low). RUN -> IDLE on stop, or on loop
//    completion (macro only). No other states.
//  - Table write: accepted in IDLE, takes effect next cycle. cfg_wr in RUN
//    dropped, cfg_err=1 the following cycle. seg_last>SEG_NUM-1 clamps.
//  - Start at edge T: at T+1 busy=1, seg_idx=0, wave_out=level[0]; latency 1.
//  - Entry k drives level[k] for exactly max(len[k],1) cycles, then seg_idx
//    advances to k+1 with no gap cycle; after seg_last, wraps to 0.
//  - Period = sum of max(len[k],1), k=0..seg_last. seg_last=0 -> constant.
//  - wrap asserted in the final cycle of entry seg_last, every loop.
//  - start while busy: ignored. start and stop same cycle in IDLE: stop
//    wins, stay IDLE. stop in RUN: next cycle IDLE, busy=0, wave_out=0,
//    seg_idx=0, wrap suppressed that cycle; current segment abandoned.
//  - rst in any state overrides all inputs, returns to reset values.
//  - Down-counter of CNT_W bits reloaded per entry; no overflow possible.
// CONFIGURATION
//  GEN_LOOP_CNT_EN defined: loop counter (LOOP_W) increments on each wrap;
//    when count reaches nonzero loop_num, the cycle after that wrap is IDLE
//    with busy=0, wave_out=0, and done=1 for 1 cycle. loop_num=0: infinite.
//  Not defined: loop_num ignored, done tied 0, runs until stop or rst.
// TESTING
//  T1 program levels 0,1,0,1 len 1,2,3,4, seg_last=3, start -> wave_out
//     0,1,1,0,0,0,1,1,1,1 repeating, period 10, wrap every 10th cycle.
//  T2 levels 1,0 len 2,2, seg_last=1 -> 50% clock, period 4; len 0,0 ->
//     period 2 (zero treated as 1).
//  T3 stop during entry 2 of T1 -> next cycle busy=0, wave_out=0,
//     seg_idx=0; restart begins at entry 0.
//  T4 cfg_wr while busy -> cfg_err pulse, table unchanged (T1 pattern
//     persists); same write in IDLE -> new pattern after next start.
//  T5 start+stop same cycle in IDLE -> busy stays 0; rst mid-RUN -> all
//     outputs at reset values next cycle, table reset to level 0, len 1.
//  T6 GEN_LOOP_CNT_EN, loop_num=3, T1 table -> 30 cycles busy, 3 wraps,
//     done=1 cycle 31, then IDLE; without macro runs past 30, done=0.

Source files
------------

// File: rtl/gen_pattern_seq.sv
// gen_pattern_seq: loops over a small programmable table of (level, length)
// segments and drives each segment's level on wave_out for its length.
// Optional feature macro: GEN_LOOP_CNT_EN (finite loop count with done pulse).
module gen_pattern_seq #(
  parameter int SEG_NUM = 4,
  parameter int SEG_AW  = 2,
  parameter int CNT_W   = 8,
  parameter int LOOP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [SEG_AW-1:0] cfg_addr,
  input  logic              cfg_level,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [SEG_AW-1:0] seg_last,
  input  logic [LOOP_W-1:0] loop_num,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              wave_out,
  output logic [SEG_AW-1:0] seg_idx,
  output logic              wrap,
  output logic              cfg_err,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [SEG_AW:0] SEG_MAX = (SEG_AW+1)'(SEG_NUM - 1);

  state_t             state;
  logic [SEG_NUM-1:0] lvl;
  logic [CNT_W-1:0]   seg_len [SEG_NUM];
  logic [SEG_AW-1:0]  last_q;
  logic [CNT_W-1:0]   cnt;

  logic [SEG_AW-1:0]  sl_clamp;
  logic               addr_ok;
  logic [CNT_W-1:0]   first_cnt;
  logic [SEG_AW-1:0]  nxt_idx;
  logic [CNT_W-1:0]   nxt_cnt;
  logic               at_last;
  logic               loop_done;

`ifdef GEN_LOOP_CNT_EN
  logic [LOOP_W-1:0]  loop_cnt;
  logic [LOOP_W-1:0]  loop_q;
`endif

  // Next-entry selection and zero-length-as-one reload values
  always_comb begin
    sl_clamp  = ({1'b0, seg_last} > SEG_MAX) ? SEG_MAX[SEG_AW-1:0] : seg_last;
    addr_ok   = ({1'b0, cfg_addr} <= SEG_MAX);
    first_cnt = (seg_len[0] == '0) ? '0 : seg_len[0] - CNT_W'(1);
    at_last   = (seg_idx == last_q);
    nxt_idx   = at_last ? '0 : seg_idx + SEG_AW'(1);
    nxt_cnt   = (seg_len[nxt_idx] == '0) ? '0 : seg_len[nxt_idx] - CNT_W'(1);
`ifdef GEN_LOOP_CNT_EN
    loop_done = at_last && (loop_q != '0) && ((loop_cnt + LOOP_W'(1)) == loop_q);
`else
    loop_done = 1'b0;
`endif
  end

`ifndef GEN_LOOP_CNT_EN
  logic unused_loop_num;
  assign unused_loop_num = ^loop_num;
  assign done = 1'b0;
`endif

  // Sequencer FSM, segment table and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      wave_out <= 1'b0;
      seg_idx  <= '0;
      wrap     <= 1'b0;
      cfg_err  <= 1'b0;
      last_q   <= '0;
      cnt      <= '0;
      lvl      <= '0;
      seg_len  <= '{default: CNT_W'(1)};
`ifdef GEN_LOOP_CNT_EN
      done     <= 1'b0;
      loop_cnt <= '0;
      loop_q   <= '0;
`endif
    end else begin
      cfg_err <= 1'b0;
      wrap    <= 1'b0;
`ifdef GEN_LOOP_CNT_EN
      done    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cfg_wr && addr_ok) begin
            lvl[cfg_addr]     <= cfg_level;
            seg_len[cfg_addr] <= cfg_len;
          end
          if (start && !stop) begin
            state    <= RUN;
            busy     <= 1'b1;
            seg_idx  <= '0;
            wave_out <= lvl[0];
            cnt      <= first_cnt;
            last_q   <= sl_clamp;
            // single-cycle entry 0 that is also the last entry wraps immediately
            wrap     <= (sl_clamp == '0) && (first_cnt == '0);
`ifdef GEN_LOOP_CNT_EN
            loop_cnt <= '0;
            loop_q   <= loop_num;
`endif
          end
        end
        RUN: begin
          if (cfg_wr) cfg_err <= 1'b1;
          if (stop || ((cnt == '0) && loop_done)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wave_out <= 1'b0;
            seg_idx  <= '0;
`ifdef GEN_LOOP_CNT_EN
            done     <= !stop;
`endif
          end else if (cnt == '0) begin
            seg_idx  <= nxt_idx;
            wave_out <= lvl[nxt_idx];
            cnt      <= nxt_cnt;
            wrap     <= (nxt_idx == last_q) && (nxt_cnt == '0);
`ifdef GEN_LOOP_CNT_EN
            if (at_last) loop_cnt <= loop_cnt + LOOP_W'(1);
`endif
          end else begin
            cnt  <= cnt - CNT_W'(1);
            wrap <= (cnt == CNT_W'(1)) && at_last;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_pattern_seq.sv
// Directed bench for gen_pattern_seq: table of pattern vectors plus
// hand-written sequences for stop, busy writes, reset and loop count.
module tb_gen_pattern_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_wr;
  logic [1:0] cfg_addr;
  logic       cfg_level;
  logic [7:0] cfg_len;
  logic [1:0] seg_last;
  logic [7:0] loop_num;
  logic       start;
  logic       stop;
  logic       busy;
  logic       wave_out;
  logic [1:0] seg_idx;
  logic       wrap;
  logic       cfg_err;
  logic       done;

  int total = 0;
  int bad   = 0;

  gen_pattern_seq #(.SEG_NUM(4), .SEG_AW(2), .CNT_W(8), .LOOP_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_level(cfg_level), .cfg_len(cfg_len), .seg_last(seg_last),
    .loop_num(loop_num), .start(start), .stop(stop), .busy(busy),
    .wave_out(wave_out), .seg_idx(seg_idx), .wrap(wrap),
    .cfg_err(cfg_err), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  lv;      // level of entry k in bit k
    logic [31:0] lens;    // length of entry k in byte k
    logic [1:0]  sl;      // seg_last
    int unsigned period;  // expected period in cycles
    logic [15:0] wave;    // expected wave_out, bit i = cycle i of a period
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic l, input logic [7:0] n);
    cfg_wr = 1'b1; cfg_addr = a; cfg_level = l; cfg_len = n;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic prog(input logic [3:0] lv, input logic [31:0] lens);
    for (int k = 0; k < 4; k++) wr(2'(k), lv[k], lens[8*k +: 8]);
  endtask

  task automatic go(input logic [1:0] sl);
    seg_last = sl; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    int unsigned p;
    int busy_n, wrap_n, done_n, done_at;
    logic [15:0] t1w;

    vecs[0] = '{lv: 4'b1010, lens: 32'h04030201, sl: 2'd3, period: 10, wave: 16'h03C6};
    vecs[1] = '{lv: 4'b0001, lens: 32'h00000202, sl: 2'd1, period: 4,  wave: 16'h0003};
    vecs[2] = '{lv: 4'b0001, lens: 32'h00000000, sl: 2'd1, period: 2,  wave: 16'h0001};
    vecs[3] = '{lv: 4'b0001, lens: 32'h00000003, sl: 2'd0, period: 3,  wave: 16'h0007};
    vecs[4] = '{lv: 4'b0011, lens: 32'h00050101, sl: 2'd2, period: 7,  wave: 16'h0003};
    t1w = 16'h03C6;

    rst = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_level = 1'b0; cfg_len = '0;
    seg_last = '0; loop_num = '0; start = 1'b0; stop = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wave", 32'(wave_out), 0);
    chk("rst_idx", 32'(seg_idx), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_done", 32'(done), 0);

    // pattern table: two full periods each
    for (int n = 0; n < 5; n++) begin
      prog(vecs[n].lv, vecs[n].lens);
      go(vecs[n].sl);
      p = vecs[n].period;
      for (int unsigned i = 0; i < 2 * p; i++) begin
        chk($sformatf("v%0d_wave_c%0d", n, i), 32'(wave_out), 32'(vecs[n].wave[i % p]));
        chk($sformatf("v%0d_wrap_c%0d", n, i), 32'(wrap), 32'((i % p) == p - 1));
        chk($sformatf("v%0d_busy_c%0d", n, i), 32'(busy), 1);
        tick();
      end
      halt();
      chk($sformatf("v%0d_stop_busy", n), 32'(busy), 0);
    end

    // stop inside entry 2, then restart from entry 0
    prog(4'b1010, 32'h04030201);
    go(2'd3);
    repeat (4) tick();
    chk("t3_idx_pre", 32'(seg_idx), 2);
    halt();
    chk("t3_busy", 32'(busy), 0);
    chk("t3_wave", 32'(wave_out), 0);
    chk("t3_idx", 32'(seg_idx), 0);
    chk("t3_wrap", 32'(wrap), 0);
    go(2'd3);
    chk("t3_re_idx0", 32'(seg_idx), 0);
    chk("t3_re_busy", 32'(busy), 1);
    tick();
    chk("t3_re_idx1", 32'(seg_idx), 1);
    chk("t3_re_wave1", 32'(wave_out), 1);

    // write while busy is dropped and flagged
    wr(2'd0, 1'b1, 8'd5);
    chk("t4_err", 32'(cfg_err), 1);
    tick();
    chk("t4_err_clr", 32'(cfg_err), 0);
    halt();
    go(2'd3);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t4_keep_c%0d", i), 32'(wave_out), 32'(t1w[i]));
      tick();
    end
    halt();
    wr(2'd0, 1'b1, 8'd5);
    chk("t4_idle_err", 32'(cfg_err), 0);
    go(2'd3);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_new_wave_c%0d", i), 32'(wave_out), 1);
      chk($sformatf("t4_new_idx_c%0d", i), 32'(seg_idx), 0);
      tick();
    end
    chk("t4_new_idx5", 32'(seg_idx), 1);
    halt();

    // start and stop together in IDLE: stop wins
    seg_last = 2'd3; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("t5_ss_busy", 32'(busy), 0);
    tick();
    chk("t5_ss_busy2", 32'(busy), 0);

    // reset mid-run restores outputs and table
    go(2'd3);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_r_busy", 32'(busy), 0);
    chk("t5_r_wave", 32'(wave_out), 0);
    chk("t5_r_idx", 32'(seg_idx), 0);
    chk("t5_r_wrap", 32'(wrap), 0);
    chk("t5_r_err", 32'(cfg_err), 0);
    chk("t5_r_done", 32'(done), 0);
    go(2'd3);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t5_tbl_idx_c%0d", i), 32'(seg_idx), 32'(i % 4));
      chk($sformatf("t5_tbl_wave_c%0d", i), 32'(wave_out), 0);
      chk($sformatf("t5_tbl_wrap_c%0d", i), 32'(wrap), 32'(i % 4 == 3));
      tick();
    end
    halt();

    // loop count: three loops of the 10-cycle pattern when enabled
    prog(4'b1010, 32'h04030201);
    loop_num = 8'd3;
    go(2'd3);
    busy_n = 0; wrap_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < 36; i++) begin
      if (busy) busy_n++;
      if (wrap) wrap_n++;
      if (done) begin
        done_n++;
        done_at = i;
      end
      tick();
    end
`ifdef GEN_LOOP_CNT_EN
    chk("t6_busy_cycles", 32'(busy_n), 30);
    chk("t6_wraps", 32'(wrap_n), 3);
    chk("t6_done_cnt", 32'(done_n), 1);
    chk("t6_done_at", 32'(done_at), 30);
    chk("t6_idle", 32'(busy), 0);
`else
    chk("t6_busy_cycles", 32'(busy_n), 36);
    chk("t6_wraps", 32'(wrap_n), 3);
    chk("t6_done_cnt", 32'(done_n), 0);
    chk("t6_still_busy", 32'(busy), 1);
`endif
    loop_num = '0;
    halt();
    chk("t6_end_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
